// File: rtl/tank_pos_tx_framer.sv
// tank_pos_tx_framer
// Transmit-side framer for the tank position link. Captures the X/Y tank
// position at the start of each frame and feeds an 8-byte frame to the
// byte-wide UART transmitter, one byte per tx_start/tx_done handshake.
// Frame: PREAMBLE_LEN x PREAMBLE_BYTE, X[7:0], X[15:8], Y[7:0], Y[15:8].
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   X_tank_pos  X position to send (16 bit)
//   Y_tank_pos  Y position to send (16 bit)
//   send        one-cycle frame request
//   tx_done     one-cycle pulse from UART TX: current byte sent
//   tx_start    one-cycle pulse: UART TX loads tx_data
//   tx_data     byte to transmit, held from tx_start until tx_done
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse the cycle after the last byte's tx_done
//
// state    | meaning
// ST_IDLE  | no frame in flight, waiting for send or refresh tick
// ST_START | tx_start asserted for the byte at idx_q
// ST_WAIT  | byte handed to UART, waiting for tx_done
module tank_pos_tx_framer #(
   parameter logic [7:0]  PREAMBLE_BYTE  = 8'hFF,
   parameter int unsigned PREAMBLE_LEN   = 4,
   parameter int unsigned REFRESH_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] X_tank_pos,
   input  logic [15:0] Y_tank_pos,
   input  logic        send,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Index of the final byte: preamble followed by four position bytes.
   localparam logic [2:0] LAST_IDX = 3'(PREAMBLE_LEN + 3);

   state_t      state_q, state_nxt;
   logic [2:0]  idx_q, idx_nxt;
   logic        pending_q, pending_nxt;
   logic [7:0]  tx_data_q, tx_data_nxt;
   logic        frame_done_q, frame_done_nxt;
   logic [15:0] x_snap_q, y_snap_q;
   logic        load_snap;
   logic        refresh_tick;
   logic        request;

   function automatic logic [7:0] byte_sel(input logic [2:0] i,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
      logic [7:0] b;
      b = PREAMBLE_BYTE;
      case (i)
         3'd4:    b = x[7:0];
         3'd5:    b = x[15:8];
         3'd6:    b = y[7:0];
         3'd7:    b = y[15:8];
         default: b = PREAMBLE_BYTE;
      endcase
      return b;
   endfunction

   // Refresh timer counts down the cycles remaining to the next tick and
   // reloads on terminal count, so a tick fires every REFRESH_CYCLES cycles
   // starting REFRESH_CYCLES-1 cycles after reset. It runs while busy too;
   // a tick during a frame just sets pending.
   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         localparam logic [31:0] RELOAD = 32'(REFRESH_CYCLES - 1);
         logic [31:0] refresh_cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               refresh_cnt <= RELOAD;
            end else if (refresh_cnt == 32'd0) begin
               refresh_cnt <= RELOAD;
            end else begin
               refresh_cnt <= refresh_cnt - 32'd1;
            end
         end

         assign refresh_tick = (refresh_cnt == 32'd0);
      end else begin : g_no_refresh
         assign refresh_tick = 1'b0;
      end
   endgenerate

   assign request = send | refresh_tick;

   always_comb begin
      state_nxt      = state_q;
      idx_nxt        = idx_q;
      pending_nxt    = pending_q;
      tx_data_nxt    = tx_data_q;
      frame_done_nxt = 1'b0;
      load_snap      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (request) begin
               load_snap   = 1'b1;
               idx_nxt     = 3'd0;
               tx_data_nxt = PREAMBLE_BYTE;
               state_nxt   = ST_START;
            end
         end
         ST_START: begin
            if (request) begin
               pending_nxt = 1'b1;
            end
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (request) begin
               pending_nxt = 1'b1;
            end
            if (tx_done) begin
               if (idx_q != LAST_IDX) begin
                  idx_nxt     = idx_q + 3'd1;
                  tx_data_nxt = byte_sel(idx_q + 3'd1, x_snap_q, y_snap_q);
                  state_nxt   = ST_START;
               end else begin
                  frame_done_nxt = 1'b1;
                  // A request landing on the final tx_done counts as pending.
                  if (pending_q || request) begin
                     pending_nxt = 1'b0;
                     load_snap   = 1'b1;
                     idx_nxt     = 3'd0;
                     tx_data_nxt = PREAMBLE_BYTE;
                     state_nxt   = ST_START;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         pending_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         idx_q        <= idx_nxt;
         pending_q    <= pending_nxt;
         tx_data_q    <= tx_data_nxt;
         frame_done_q <= frame_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_snap_q <= 16'h0000;
         y_snap_q <= 16'h0000;
      end else if (load_snap) begin
         x_snap_q <= X_tank_pos;
         y_snap_q <= Y_tank_pos;
      end
   end

   assign tx_start   = (state_q == ST_START);
   assign busy       = (state_q != ST_IDLE);
   assign tx_data    = tx_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tank_pos_tx_framer.sv
// Testbench for tank_pos_tx_framer: table of whole-frame vectors, directed
// multi-cycle sequences, a randomized run against a frame-level reference
// model, and a second instance exercising the auto-refresh timer.
module tb_tank_pos_tx_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] X_tank_pos, Y_tank_pos;
   logic        send;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy, frame_done;

   logic        r_send = 1'b0;
   logic [15:0] r_x = 16'hBEEF;
   logic [15:0] r_y = 16'h1357;
   logic        r_tx_done;
   logic        r_tx_start;
   logic [7:0]  r_tx_data;
   logic        r_busy, r_frame_done;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tank_pos_tx_framer u_dut (
      .clk(clk), .rst(rst), .X_tank_pos(X_tank_pos), .Y_tank_pos(Y_tank_pos),
      .send(send), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
      .busy(busy), .frame_done(frame_done)
   );

   tank_pos_tx_framer #(.REFRESH_CYCLES(1000)) u_ref (
      .clk(clk), .rst(rst), .X_tank_pos(r_x), .Y_tank_pos(r_y),
      .send(r_send), .tx_done(r_tx_done), .tx_start(r_tx_start), .tx_data(r_tx_data),
      .busy(r_busy), .frame_done(r_frame_done)
   );

   // Expected frame byte i for a position pair, from the frame layout.
   function automatic logic [7:0] frame_byte(input int i, input logic [15:0] x,
                                             input logic [15:0] y);
      logic [31:0] w;
      w = {y, x};
      if (i < 4) return 8'hFF;
      return w[8*(i-4) +: 8];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // UART TX model for the main instance: tx_done tx_delay cycles after tx_start.
   int   tx_delay = 10;
   int   resp_cnt = 0;
   logic resp_en;
   logic tx_done_auto = 1'b0;
   logic tx_done_rnd;
   assign tx_done = resp_en ? tx_done_auto : tx_done_rnd;

   always @(negedge clk) begin
      tx_done_auto = 1'b0;
      if (!rst) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) tx_done_auto = 1'b1;
         end
         if (tx_start) resp_cnt = tx_delay;
      end
   end

   // Capture of the main instance's output stream.
   logic [7:0] cap_q[$];
   int   start_cnt = 0;
   int   fd_cnt = 0;
   logic track_busy = 1'b0;
   int   busy_stop_fd = 0;

   always @(negedge clk) begin
      if (tx_start) begin
         cap_q.push_back(tx_data);
         start_cnt++;
      end
      if (frame_done) fd_cnt++;
      if (track_busy && !busy) begin
         track_busy   = 1'b0;
         busy_stop_fd = fd_cnt;
      end
   end

   // UART model and monitor for the refresh instance.
   int          r_delay = 1;
   int          r_cnt = 0;
   int          r_starts = 0;
   int          r_bad = 0;
   int unsigned r_frame_t[$];
   logic        r_track = 1'b0;
   logic        r_drop = 1'b0;

   always @(negedge clk) begin
      r_tx_done = 1'b0;
      if (!rst) begin
         r_cnt    = 0;
         r_starts = 0;
      end else begin
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) r_tx_done = 1'b1;
         end
         if (r_tx_start) begin
            r_cnt = r_delay;
            if (r_starts % 8 == 0) r_frame_t.push_back(cyc);
            if (r_tx_data !== frame_byte(r_starts % 8, r_x, r_y)) r_bad++;
            r_starts++;
         end
         if (r_track && !r_busy) r_drop = 1'b1;
      end
   end

   task automatic clear_mon();
      cap_q.delete();
      start_cnt    = 0;
      fd_cnt       = 0;
      busy_stop_fd = 0;
   endtask

   task automatic pulse_send(output logic started);
      @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      started = tx_start;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({name, " idle timeout"}, 64'(k >= budget), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [63:0] pack8(input int off);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         v = {v[55:0], (off + i < cap_q.size()) ? cap_q[off + i] : 8'h00};
      return v;
   endfunction

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      int          delay;
      logic [63:0] exp;
   } vec_t;

   // Frame-level reference model state for the randomized run.
   logic        m_busy, m_pend, m_start, m_fd;
   int          m_sent;
   logic [15:0] m_x, m_y;

   task automatic model_step(input logic s, input logic d, input logic [15:0] x,
                             input logic [15:0] y);
      logic was_start;
      was_start = m_start;
      m_start   = 1'b0;
      m_fd      = 1'b0;
      if (!m_busy) begin
         if (s) begin
            m_x = x; m_y = y; m_sent = 0; m_busy = 1'b1; m_start = 1'b1;
         end
      end else begin
         if (s) m_pend = 1'b1;
         if (d && !was_start) begin
            m_sent++;
            if (m_sent == 8) begin
               m_fd = 1'b1;
               if (m_pend) begin
                  m_pend = 1'b0; m_x = x; m_y = y; m_sent = 0; m_start = 1'b1;
               end else begin
                  m_busy = 1'b0;
               end
            end else begin
               m_start = 1'b1;
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      logic started;
      int   k;
      logic s, d;

      vecs[0] = '{16'h1234, 16'hABCD, 10, 64'hFFFFFFFF_3412_CDAB};
      vecs[1] = '{16'h0000, 16'h0000, 1,  64'hFFFFFFFF_0000_0000};
      vecs[2] = '{16'hFFFF, 16'hFF00, 3,  64'hFFFFFFFF_FFFF_00FF};
      vecs[3] = '{16'h00FF, 16'h8001, 2,  64'hFFFFFFFF_FF00_0180};

      rst = 1'b0; send = 1'b0; X_tank_pos = 16'h0; Y_tank_pos = 16'h0;
      resp_en = 1'b1; tx_done_rnd = 1'b0;
      repeat (3) @(negedge clk);
      check("reset tx_start", 64'(tx_start), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset tx_data", 64'(tx_data), 64'd0);
      check("reset frame_done", 64'(frame_done), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle busy", 64'(busy), 64'd0);

      // Whole-frame vectors.
      for (int i = 0; i < 4; i++) begin
         X_tank_pos = vecs[i].x; Y_tank_pos = vecs[i].y; tx_delay = vecs[i].delay;
         clear_mon();
         pulse_send(started);
         check("first tx_start latency", 64'(started), 64'd1);
         wait_idle("vector", 400);
         check("vector bytes", pack8(0), vecs[i].exp);
         check("vector tx_start count", 64'(start_cnt), 64'd8);
         check("vector frame_done count", 64'(fd_cnt), 64'd1);
         check("vector busy after", 64'(busy), 64'd0);
      end

      // Input change mid-frame does not reach the frame in flight.
      X_tank_pos = 16'h0001; Y_tank_pos = 16'h2222; tx_delay = 4;
      clear_mon();
      pulse_send(started);
      k = 0;
      while (start_cnt < 3 && k < 200) begin @(negedge clk); k++; end
      X_tank_pos = 16'h5555;
      wait_idle("midchange", 400);
      check("midchange bytes", pack8(0), 64'hFFFFFFFF_0100_2222);

      // Three requests during a frame merge into one back-to-back frame,
      // which re-snapshots the position.
      X_tank_pos = 16'h0A0B; Y_tank_pos = 16'h0C0D; tx_delay = 6;
      clear_mon();
      pulse_send(started);
      track_busy = 1'b1;
      repeat (3) begin
         repeat (5) @(negedge clk);
         pulse_send(started);
      end
      X_tank_pos = 16'h7788;
      wait_idle("merge", 1000);
      check("merge tx_start count", 64'(start_cnt), 64'd16);
      check("merge frame_done count", 64'(fd_cnt), 64'd2);
      check("merge busy held", 64'(busy_stop_fd), 64'd2);
      check("merge frame1", pack8(0), 64'hFFFFFFFF_0B0A_0D0C);
      check("merge frame2", pack8(8), 64'hFFFFFFFF_8877_0D0C);

      // Request coincident with the last tx_done.
      X_tank_pos = 16'h1111; Y_tank_pos = 16'h2222; tx_delay = 5;
      clear_mon();
      pulse_send(started);
      track_busy = 1'b1;
      k = 1;
      for (int n = 0; n < 400 && k < 8; n++) begin
         @(negedge clk);
         if (tx_start) k++;
      end
      repeat (5) @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      wait_idle("coincident", 1000);
      check("coincident tx_start count", 64'(start_cnt), 64'd16);
      check("coincident frame_done count", 64'(fd_cnt), 64'd2);
      check("coincident busy held", 64'(busy_stop_fd), 64'd2);

      // Asynchronous reset while waiting on byte 5.
      X_tank_pos = 16'hABCD; Y_tank_pos = 16'h1234; tx_delay = 10;
      clear_mon();
      pulse_send(started);
      k = 0;
      while (start_cnt < 6 && k < 200) begin @(negedge clk); k++; end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async reset tx_start", 64'(tx_start), 64'd0);
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset tx_data", 64'(tx_data), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      X_tank_pos = 16'hCAFE; Y_tank_pos = 16'hF00D; tx_delay = 2;
      repeat (2) @(negedge clk);
      clear_mon();
      pulse_send(started);
      check("post-reset latency", 64'(started), 64'd1);
      wait_idle("post-reset", 400);
      check("post-reset bytes", pack8(0), 64'hFFFFFFFF_FECA_0DF0);
      check("post-reset tx_start count", 64'(start_cnt), 64'd8);

      // Spurious tx_done while idle.
      resp_en = 1'b0;
      clear_mon();
      repeat (3) begin
         @(negedge clk); tx_done_rnd = 1'b1;
         @(negedge clk); tx_done_rnd = 1'b0;
      end
      @(negedge clk);
      check("spurious tx_start count", 64'(start_cnt), 64'd0);
      check("spurious busy", 64'(busy), 64'd0);
      resp_en = 1'b1;
      X_tank_pos = 16'h4321; Y_tank_pos = 16'h8765; tx_delay = 1;
      pulse_send(started);
      wait_idle("after spurious", 400);
      check("after spurious bytes", pack8(0), 64'hFFFFFFFF_2143_6587);

      // Randomized run against the frame-level model.
      resp_en = 1'b0;
      m_busy = 1'b0; m_pend = 1'b0; m_start = 1'b0; m_fd = 1'b0; m_sent = 0;
      m_x = '0; m_y = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         s = ($urandom_range(0, 15) == 0);
         d = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) X_tank_pos = 16'($urandom);
         if ($urandom_range(0, 7) == 0) Y_tank_pos = 16'($urandom);
         send = s;
         tx_done_rnd = d;
         @(posedge clk);
         model_step(s, d, X_tank_pos, Y_tank_pos);
         #1;
         check("rand tx_start", 64'(tx_start), 64'(m_start));
         check("rand busy", 64'(busy), 64'(m_busy));
         check("rand frame_done", 64'(frame_done), 64'(m_fd));
         if (m_busy)
            check("rand tx_data", 64'(tx_data), 64'(frame_byte(m_sent, m_x, m_y)));
      end
      @(negedge clk);
      send = 1'b0; tx_done_rnd = 1'b0;

      // Auto-refresh with a fast UART: one frame every 1000 cycles.
      rst = 1'b0;
      r_frame_t.delete();
      r_delay = 1; r_bad = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3500) @(negedge clk);
      check("refresh fast frame count", 64'(r_frame_t.size() >= 3), 64'd1);
      for (int i = 1; i < r_frame_t.size(); i++)
         check("refresh fast period", 64'(r_frame_t[i] - r_frame_t[i-1]), 64'd1000);

      // Slow UART: a frame outlasts the period, so frames run back-to-back.
      rst = 1'b0;
      r_frame_t.delete();
      r_delay = 150; r_drop = 1'b0; r_track = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      k = 0;
      while (r_frame_t.size() < 1 && k < 1200) begin @(negedge clk); k++; end
      check("refresh slow first frame", 64'(k >= 1200), 64'd0);
      r_track = 1'b1;
      repeat (3000) @(negedge clk);
      r_track = 1'b0;
      check("refresh slow frame count", 64'(r_frame_t.size() >= 3), 64'd1);
      for (int i = 1; i < r_frame_t.size(); i++)
         check("refresh slow period", 64'(r_frame_t[i] - r_frame_t[i-1]), 64'd1208);
      check("refresh slow busy held", 64'(r_drop), 64'd0);
      check("refresh byte errors", 64'(r_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
